// File: rtl/l2_conv2x2.sv
// ---------------------------------------------------------------------------
// l2_conv2x2
//   Layer-2 2x2 convolution stage. Walks every 2x2 window of the MAP_W x MAP_W
//   layer-2 feature map (anchors at row 1..MAP_W-1, col 1..MAP_W-1, linear
//   address row*MAP_W+col), reads the four taps from the feature-map RAM,
//   computes sum(dinN*wN) + (bias<<FRAC), rescales to Q.FRAC with saturation
//   and streams (MAP_W-1)^2 results over a valid/ready handshake.
//
//   Build option: define RELU_EN to clamp negative results to zero after
//   saturation. Latency and handshake are identical in both builds.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 one-cycle pass request, honoured only when idle
//   w0..w3                signed weights for taps addr-12, addr-11, addr-1, addr
//   bias                  signed bias, Q.FRAC
//   rd, addr_rd           RAM read enable and window anchor address
//   din0..din3            RAM taps (same order as weights), combinational
//   out_data, out_addr    signed result and its row-major index
//   out_valid, out_ready  result handshake
//   busy                  high from accepted start until done
//   done                  one-cycle pulse after the last result is accepted
// ---------------------------------------------------------------------------
module l2_conv2x2 #(
  parameter int DW    = 18,
  parameter int FRAC  = 8,
  parameter int MAP_W = 11,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] w0,
  input  logic [DW-1:0] w1,
  input  logic [DW-1:0] w2,
  input  logic [DW-1:0] w3,
  input  logic [DW-1:0] bias,
  output logic          rd,
  output logic [AW-1:0] addr_rd,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din3,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam int PW = 2 * DW;      // product width
  localparam int SW = 2 * DW + 2;  // accumulator width (4 products + bias)
  localparam int CW = $clog2(MAP_W);

  localparam logic [AW-1:0] FIRST_ANCHOR = AW'(MAP_W + 1);
  localparam logic [AW-1:0] LAST_ANCHOR  = AW'(MAP_W * MAP_W - 1);
  localparam logic [CW-1:0] LAST_COL     = CW'(MAP_W - 1);

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]        RES_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]        RES_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] anchor_q, anchor_d;
  logic [CW-1:0] col_q, col_d;
  logic          clr_idx;
  logic          stall;

  // Pipeline state: S1 products, S2 accumulator, S3 result (output regs).
  logic                 v1_q, v2_q, v3_q;
  logic signed [PW-1:0] prod_q [4];
  logic signed [PW-1:0] prod   [4];
  logic signed [SW-1:0] sum_q, sum_d;
  logic signed [SW-1:0] bias_ext;
  logic signed [SW-1:0] shifted;
  logic        [DW-1:0] sat;
  logic        [DW-1:0] res_q, res_d;
  logic        [AW-1:0] res_idx_q;
  logic        [AW-1:0] out_addr_q;

  // A result sitting in S3 that downstream refuses freezes the whole stage.
  assign stall = v3_q && !out_ready;

  // ---------------------------------------------------------------------
  // Control FSM and window address generator
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q  <= IDLE;
      anchor_q <= '0;
      col_q    <= '0;
    end else begin
      state_q  <= state_d;
      anchor_q <= anchor_d;
      col_q    <= col_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d  = state_q;
    anchor_d = anchor_q;
    col_d    = col_q;
    rd       = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    clr_idx  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          anchor_d = FIRST_ANCHOR;
          col_d    = CW'(1);
          clr_idx  = 1'b1;
        end
      end

      RUN: begin
        busy = 1'b1;
        // A stalled cycle issues nothing; the same anchor goes out again
        // with rd=1 once the stall releases.
        if (!stall) begin
          rd = 1'b1;
          if (anchor_q == LAST_ANCHOR) begin
            state_d  = DRAIN;
            anchor_d = '0;
            col_d    = '0;
          end else if (col_q == LAST_COL) begin
            // Skip column 0 of the next row.
            anchor_d = anchor_q + AW'(2);
            col_d    = CW'(1);
          end else begin
            anchor_d = anchor_q + AW'(1);
            col_d    = col_q + CW'(1);
          end
        end
      end

      DRAIN: begin
        busy = 1'b1;
        // Empty once S1/S2 are clear and S3 is either empty or being taken.
        if (!v1_q && !v2_q && (!v3_q || out_ready)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign addr_rd = anchor_q;

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  assign prod[0] = $signed(din0) * $signed(w0);
  assign prod[1] = $signed(din1) * $signed(w1);
  assign prod[2] = $signed(din2) * $signed(w2);
  assign prod[3] = $signed(din3) * $signed(w3);

  assign bias_ext = SW'($signed(bias)) <<< FRAC;
  assign sum_d    = SW'(prod_q[0]) + SW'(prod_q[1]) + SW'(prod_q[2])
                  + SW'(prod_q[3]) + bias_ext;

  // Arithmetic shift floors toward -inf; then clip to the DW-bit range.
  assign shifted = sum_q >>> FRAC;

  always_comb begin
    if (shifted > SAT_MAX) begin
      sat = RES_MAX;
    end else if (shifted < SAT_MIN) begin
      sat = RES_MIN;
    end else begin
      sat = shifted[DW-1:0];
    end
`ifdef RELU_EN
    res_d = sat[DW-1] ? '0 : sat;
`else
    res_d = sat;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too so out_data reads 0 after reset;
    // the valid bits alone decide whether their contents mean anything.
    if (!rst_n) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      prod_q     <= '{default: '0};
      sum_q      <= '0;
      res_q      <= '0;
      res_idx_q  <= '0;
      out_addr_q <= '0;
    end else if (clr_idx) begin
      res_idx_q <= '0;
    end else if (!stall) begin
      v1_q <= rd;
      if (rd) begin
        prod_q <= prod;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        sum_q <= sum_d;
      end
      v3_q <= v2_q;
      if (v2_q) begin
        res_q      <= res_d;
        out_addr_q <= res_idx_q;
        res_idx_q  <= res_idx_q + AW'(1);
      end
    end
  end

  assign out_valid = v3_q;
  assign out_data  = res_q;
  assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_l2_conv2x2.sv
module tb_l2_conv2x2;

  localparam int DW      = 18;
  localparam int AW      = 7;
  localparam int N_RES   = 100;
  localparam int TIMEOUT = 4000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] w0, w1, w2, w3, bias;
  logic [DW-1:0] din0, din1, din2, din3;
  logic          rd, out_valid, busy, done;
  logic [AW-1:0] addr_rd, out_addr;
  logic [DW-1:0] out_data;

  // Reference state: feature map, weights, bias as plain integers.
  int ram [121];
  int wt  [4];
  int bias_v;

  int n_vec = 0;
  int n_err = 0;

  // Per-pass observations.
  int got_data  [N_RES];
  int got_addr  [N_RES];
  int issue_log [128];
  int n_res, n_issue, n_done, done_cyc, stall_cycles, stall_viol;
  bit busy_at_start30;

  always #5 clk = ~clk;

  assign w0   = DW'(wt[0]);
  assign w1   = DW'(wt[1]);
  assign w2   = DW'(wt[2]);
  assign w3   = DW'(wt[3]);
  assign bias = DW'(bias_v);

  // RAM taps: combinational read around the anchor.
  always_comb begin
    din0 = '0;
    din1 = '0;
    din2 = '0;
    din3 = '0;
    if (addr_rd >= AW'(12) && addr_rd <= AW'(120)) begin
      din0 = DW'(ram[int'(addr_rd) - 12]);
      din1 = DW'(ram[int'(addr_rd) - 11]);
      din2 = DW'(ram[int'(addr_rd) - 1]);
      din3 = DW'(ram[int'(addr_rd)]);
    end
  end

  l2_conv2x2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .w0        (w0),
    .w1        (w1),
    .w2        (w2),
    .w3        (w3),
    .bias      (bias),
    .rd        (rd),
    .addr_rd   (addr_rd),
    .din0      (din0),
    .din1      (din1),
    .din2      (din2),
    .din3      (din3),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  // Window anchor of result index i (row-major over rows/cols 1..10).
  function automatic int anchor_of(int i);
    return (i / 10 + 1) * 11 + (i % 10) + 1;
  endfunction

  // Expected result: exact integer arithmetic, floor shift, clip, optional ReLU.
  function automatic int model(int i);
    int     a;
    longint acc;
    a   = anchor_of(i);
    acc = longint'(wt[0]) * ram[a - 12] + longint'(wt[1]) * ram[a - 11]
        + longint'(wt[2]) * ram[a - 1]  + longint'(wt[3]) * ram[a]
        + longint'(bias_v) * 256;
    acc = acc >>> 8;
    if (acc > 131071)  acc = 131071;
    if (acc < -131072) acc = -131072;
`ifdef RELU_EN
    if (acc < 0) acc = 0;
`endif
    return int'(acc);
  endfunction

  function automatic int rand_s18();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  // rmode: 0 = out_ready always high, 1 = random out_ready.
  task automatic run_pass(input int rmode, input bit stall50, input bit start30,
                          input int abort_at);
    int          cyc, hold_left, tail;
    bit          seen_done, pulsed30, pulsed50, stalled_prev;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    n_res = 0; n_issue = 0; n_done = 0; done_cyc = -1;
    stall_cycles = 0; stall_viol = 0; busy_at_start30 = 1'b0;
    cyc = 0; hold_left = 0; tail = 0;
    seen_done = 0; pulsed30 = 0; pulsed50 = 0; stalled_prev = 0;
    prev_data = '0; prev_addr = '0;
    @(negedge clk);
    start = 1'b1;
    while (cyc < TIMEOUT && tail < 4) begin
      if (stall50 && !pulsed50 && out_valid === 1'b1 && out_addr === AW'(50)) begin
        hold_left = 5;
        pulsed50  = 1'b1;
      end
      if (hold_left > 0) begin
        out_ready = 1'b0;
        hold_left--;
      end else if (rmode == 1) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
      if (cyc > 0) begin
        start = start30 && !pulsed30 && (n_res == 30);
        if (start) begin
          pulsed30        = 1'b1;
          busy_at_start30 = busy;
        end
      end
      #1;
      if (stalled_prev && (out_data !== prev_data || out_addr !== prev_addr
                           || out_valid !== 1'b1)) stall_viol++;
      if (out_valid === 1'b1 && !out_ready) begin
        stall_cycles++;
        if (rd !== 1'b0) stall_viol++;
      end
      stalled_prev = (out_valid === 1'b1) && !out_ready;
      prev_data    = out_data;
      prev_addr    = out_addr;
      if (rd === 1'b1) begin
        if (n_issue < 128) issue_log[n_issue] = int'(addr_rd);
        n_issue++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        if (n_res < N_RES) begin
          got_data[n_res] = int'($signed(out_data));
          got_addr[n_res] = int'(out_addr);
        end
        n_res++;
      end
      if (done === 1'b1) begin
        n_done++;
        if (!seen_done) done_cyc = cyc + 1;
        seen_done = 1'b1;
      end
      if (seen_done) tail++;
      if (abort_at > 0 && n_res == abort_at) break;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (rd !== 1'b0)        begin n_err++; $display("FAIL reset_rd got=%b want=0", rd); end
    n_vec++; if (addr_rd !== '0)     begin n_err++; $display("FAIL reset_addr_rd got=%0d want=0", addr_rd); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_vec++; if (out_data !== '0)    begin n_err++; $display("FAIL reset_out_data got=%0h want=0", out_data); end
    n_vec++; if (out_addr !== '0)    begin n_err++; $display("FAIL reset_out_addr got=%0d want=0", out_addr); end
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
  endtask

  task automatic test_ramp();
    for (int k = 0; k < 121; k++) ram[k] = k << 8;
    for (int j = 0; j < 4; j++) wt[j] = 256;
    bias_v = 0;
    run_pass(0, 1'b0, 1'b0, 0);
    n_vec++; if (n_res !== N_RES) begin n_err++; $display("FAIL ramp_count got=%0d want=%0d", n_res, N_RES); end
    for (int i = 0; i < N_RES && i < n_res; i++) begin
      n_vec++;
      if (got_data[i] !== (4 * anchor_of(i) - 24) * 256 || got_addr[i] !== i) begin
        n_err++;
        $display("FAIL ramp_result[%0d] got=%0d@%0d want=%0d@%0d", i, got_data[i],
                 got_addr[i], (4 * anchor_of(i) - 24) * 256, i);
      end
    end
    n_vec++; if (got_data[0] !== 6144)    begin n_err++; $display("FAIL ramp_first got=%0d want=6144", got_data[0]); end
    n_vec++; if (got_data[99] !== 116736) begin n_err++; $display("FAIL ramp_last got=%0d want=116736", got_data[99]); end
    n_vec++; if (n_done !== 1)            begin n_err++; $display("FAIL ramp_done_pulses got=%0d want=1", n_done); end
    n_vec++; if (done_cyc !== 105)        begin n_err++; $display("FAIL ramp_cycles got=%0d want=105", done_cyc); end
    n_vec++; if (stall_cycles !== 0)      begin n_err++; $display("FAIL ramp_bubbles stalls=%0d want=0", stall_cycles); end
    idle_cycles(2);
  endtask

  task automatic test_address_sweep();
    for (int k = 0; k < 121; k++) ram[k] = rand_s18() >>> 4;
    for (int j = 0; j < 4; j++) wt[j] = int'($urandom_range(0, 1023)) - 512;
    bias_v = rand_s18() >>> 2;
    run_pass(1, 1'b0, 1'b0, 0);
    n_vec++; if (n_issue !== N_RES) begin n_err++; $display("FAIL sweep_issues got=%0d want=%0d", n_issue, N_RES); end
    for (int i = 0; i < N_RES && i < n_issue; i++) begin
      n_vec++;
      if (issue_log[i] !== anchor_of(i)) begin
        n_err++;
        $display("FAIL sweep_addr[%0d] got=%0d want=%0d", i, issue_log[i], anchor_of(i));
      end
    end
    n_vec++; if (n_res !== N_RES) begin n_err++; $display("FAIL sweep_count got=%0d want=%0d", n_res, N_RES); end
    for (int i = 0; i < N_RES && i < n_res; i++) begin
      n_vec++;
      if (got_data[i] !== model(i) || got_addr[i] !== i) begin
        n_err++;
        $display("FAIL sweep_result[%0d] got=%0d@%0d want=%0d@%0d", i, got_data[i], got_addr[i], model(i), i);
      end
    end
    n_vec++; if (stall_viol !== 0) begin n_err++; $display("FAIL sweep_stall_hold violations=%0d want=0", stall_viol); end
    n_vec++; if (n_done !== 1)     begin n_err++; $display("FAIL sweep_done_pulses got=%0d want=1", n_done); end
    idle_cycles(2);
  endtask

  task automatic test_saturation();
    int want_neg;
`ifdef RELU_EN
    want_neg = 0;
`else
    want_neg = -131072;
`endif
    for (int k = 0; k < 121; k++) ram[k] = 131071;
    for (int j = 0; j < 4; j++) wt[j] = 131071;
    bias_v = 0;
    run_pass(0, 1'b0, 1'b0, 0);
    n_vec++; if (n_res !== N_RES) begin n_err++; $display("FAIL satpos_count got=%0d want=%0d", n_res, N_RES); end
    for (int i = 0; i < N_RES && i < n_res; i++) begin
      n_vec++;
      if (got_data[i] !== 131071) begin
        n_err++;
        $display("FAIL satpos_result[%0d] got=%0d want=131071", i, got_data[i]);
      end
    end
    idle_cycles(2);
    for (int k = 0; k < 121; k++) ram[k] = -131072;
    run_pass(0, 1'b0, 1'b0, 0);
    n_vec++; if (n_res !== N_RES) begin n_err++; $display("FAIL satneg_count got=%0d want=%0d", n_res, N_RES); end
    for (int i = 0; i < N_RES && i < n_res; i++) begin
      n_vec++;
      if (got_data[i] !== want_neg) begin
        n_err++;
        $display("FAIL satneg_result[%0d] got=%0d want=%0d", i, got_data[i], want_neg);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 121; k++) ram[k] = rand_s18();
    for (int j = 0; j < 4; j++) wt[j] = int'($urandom_range(0, 511)) - 256;
    bias_v = rand_s18();
    run_pass(0, 1'b1, 1'b0, 0);
    n_vec++; if (stall_cycles !== 5) begin n_err++; $display("FAIL bp_stall_cycles got=%0d want=5", stall_cycles); end
    n_vec++; if (stall_viol !== 0)   begin n_err++; $display("FAIL bp_hold violations=%0d want=0", stall_viol); end
    n_vec++; if (n_res !== N_RES)    begin n_err++; $display("FAIL bp_count got=%0d want=%0d", n_res, N_RES); end
    n_vec++; if (n_issue !== N_RES)  begin n_err++; $display("FAIL bp_issues got=%0d want=%0d", n_issue, N_RES); end
    for (int i = 0; i < N_RES && i < n_res; i++) begin
      n_vec++;
      if (got_data[i] !== model(i) || got_addr[i] !== i) begin
        n_err++;
        $display("FAIL bp_result[%0d] got=%0d@%0d want=%0d@%0d", i, got_data[i], got_addr[i], model(i), i);
      end
    end
    n_vec++; if (done_cyc !== 110) begin n_err++; $display("FAIL bp_cycles got=%0d want=110", done_cyc); end
    idle_cycles(2);
  endtask

  task automatic test_start_ignored();
    for (int k = 0; k < 121; k++) ram[k] = rand_s18() >>> 3;
    for (int j = 0; j < 4; j++) wt[j] = rand_s18() >>> 6;
    bias_v = rand_s18() >>> 4;
    run_pass(0, 1'b0, 1'b1, 0);
    n_vec++; if (busy_at_start30 !== 1'b1) begin n_err++; $display("FAIL start30_busy got=%b want=1", busy_at_start30); end
    n_vec++; if (n_res !== N_RES)   begin n_err++; $display("FAIL start30_count got=%0d want=%0d", n_res, N_RES); end
    n_vec++; if (done_cyc !== 105)  begin n_err++; $display("FAIL start30_cycles got=%0d want=105", done_cyc); end
    n_vec++; if (n_done !== 1)      begin n_err++; $display("FAIL start30_done_pulses got=%0d want=1", n_done); end
    for (int i = 0; i < N_RES && i < n_res; i++) begin
      n_vec++;
      if (got_data[i] !== model(i) || got_addr[i] !== i) begin
        n_err++;
        $display("FAIL start30_result[%0d] got=%0d@%0d want=%0d@%0d", i, got_data[i], got_addr[i], model(i), i);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_reset_midpass();
    for (int k = 0; k < 121; k++) ram[k] = rand_s18();
    for (int j = 0; j < 4; j++) wt[j] = int'($urandom_range(0, 2047)) - 1024;
    bias_v = rand_s18();
    run_pass(0, 1'b0, 1'b0, 40);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (rd !== 1'b0)        begin n_err++; $display("FAIL midrst_rd got=%b want=0", rd); end
    n_vec++; if (addr_rd !== '0)     begin n_err++; $display("FAIL midrst_addr_rd got=%0d want=0", addr_rd); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    n_vec++; if (out_data !== '0)    begin n_err++; $display("FAIL midrst_out_data got=%0h want=0", out_data); end
    n_vec++; if (out_addr !== '0)    begin n_err++; $display("FAIL midrst_out_addr got=%0d want=0", out_addr); end
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL midrst_busy got=%b want=0", busy); end
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(2);
    run_pass(1, 1'b0, 1'b0, 0);
    n_vec++; if (issue_log[0] !== 12) begin n_err++; $display("FAIL midrst_first_addr got=%0d want=12", issue_log[0]); end
    n_vec++; if (n_res !== N_RES)     begin n_err++; $display("FAIL midrst_count got=%0d want=%0d", n_res, N_RES); end
    for (int i = 0; i < N_RES && i < n_res; i++) begin
      n_vec++;
      if (got_data[i] !== model(i) || got_addr[i] !== i) begin
        n_err++;
        $display("FAIL midrst_result[%0d] got=%0d@%0d want=%0d@%0d", i, got_data[i], got_addr[i], model(i), i);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_bias_only();
    int want;
`ifdef RELU_EN
    want = 0;
`else
    want = -256;
`endif
    for (int k = 0; k < 121; k++) ram[k] = 0;
    for (int j = 0; j < 4; j++) wt[j] = 256;
    bias_v = -256;
    run_pass(0, 1'b0, 1'b0, 0);
    n_vec++; if (n_res !== N_RES) begin n_err++; $display("FAIL bias_count got=%0d want=%0d", n_res, N_RES); end
    for (int i = 0; i < N_RES && i < n_res; i++) begin
      n_vec++;
      if (got_data[i] !== want) begin
        n_err++;
        $display("FAIL bias_result[%0d] got=%0d want=%0d", i, got_data[i], want);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_random();
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 121; k++) ram[k] = rand_s18();
      for (int j = 0; j < 4; j++) wt[j] = (p == 0) ? rand_s18() : (rand_s18() >>> (4 + p));
      bias_v = rand_s18();
      run_pass(1, 1'b0, 1'b0, 0);
      n_vec++; if (n_res !== N_RES) begin n_err++; $display("FAIL rand%0d_count got=%0d want=%0d", p, n_res, N_RES); end
      n_vec++; if (stall_viol !== 0) begin n_err++; $display("FAIL rand%0d_hold violations=%0d want=0", p, stall_viol); end
      for (int i = 0; i < N_RES && i < n_res; i++) begin
        n_vec++;
        if (got_data[i] !== model(i) || got_addr[i] !== i) begin
          n_err++;
          $display("FAIL rand%0d_result[%0d] got=%0d@%0d want=%0d@%0d", p, i, got_data[i],
                   got_addr[i], model(i), i);
        end
      end
      idle_cycles(2);
    end
  endtask

  initial begin
    for (int k = 0; k < 121; k++) ram[k] = 0;
    for (int j = 0; j < 4; j++) wt[j] = 0;
    bias_v = 0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    idle_cycles(2);
    test_ramp();
    test_address_sweep();
    test_saturation();
    test_backpressure();
    test_start_ignored();
    test_reset_midpass();
    test_bias_only();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
